// File: rtl/sys_xbus_master_pkg.sv
// Shared types for the system register bus initiator: FSM states and response error codes.
package sys_xbus_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [1:0] ERR_OK  = 2'b00;
   localparam logic [1:0] ERR_TMO = 2'b01;
   localparam logic [1:0] ERR_DEC = 2'b10;

endpackage

// File: rtl/sys_xbus_master_tmo_cnt.sv
// Ack-timeout counter: cleared outside the bus phase, counts stb cycles without ack.
module sys_xbus_tmo_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flags the cycle whose increment makes the count reach TIMEOUT_CYCLES.
   assign expired_o = en_i & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sys_xbus_master.sv
// Wishbone classic initiator: one command in, one bus cycle (or decode/timeout error), one response out.
module sys_xbus_master
   import sys_xbus_master_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           SELECT_WIDTH   = DATA_WIDTH / 8,
   parameter logic [ADDR_WIDTH-1:0] REG_ADDR_BASE  = 32'h1000_0000,
   parameter int unsigned           NUM_REG        = 64,
   parameter int unsigned           TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_we,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [SELECT_WIDTH-1:0] cmd_sel,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_err,
   output logic [ADDR_WIDTH-1:0]   adr_o,
   output logic [DATA_WIDTH-1:0]   dat_o,
   output logic                    we_o,
   output logic [SELECT_WIDTH-1:0] sel_o,
   output logic                    stb_o,
   output logic                    cyc_o,
   input  logic [DATA_WIDTH-1:0]   dat_i,
   input  logic                    ack_i
);

   // One extra bit so BASE + size cannot wrap past the top of the address space.
   localparam logic [ADDR_WIDTH:0]   WIN_LO     = {1'b0, REG_ADDR_BASE};
   localparam logic [ADDR_WIDTH:0]   WIN_HI     = WIN_LO + (ADDR_WIDTH + 1)'(NUM_REG * SELECT_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(SELECT_WIDTH - 1);

   state_t                  state_q, state_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]              rsp_err_q, rsp_err_d;
   logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
   logic [DATA_WIDTH-1:0]   dat_q, dat_d;
   logic                    we_q, we_d;
   logic [SELECT_WIDTH-1:0] sel_q, sel_d;
   logic                    stb_q, stb_d;
   logic                    cyc_q, cyc_d;

   logic                    addr_ok;
   logic                    tmo_clr, tmo_en, tmo_expired;

   assign addr_ok = ({1'b0, cmd_addr} >= WIN_LO) && ({1'b0, cmd_addr} < WIN_HI) &&
                    ((cmd_addr & ALIGN_MASK) == '0);

   assign tmo_clr = (state_q != ST_BUS);
   assign tmo_en  = (state_q == ST_BUS) & ~ack_i;

   sys_xbus_tmo_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_tmo_cnt (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .clr_i     (tmo_clr),
      .en_i      (tmo_en),
      .expired_o (tmo_expired)
   );

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      we_d        = we_q;
      sel_d       = sel_q;
      stb_d       = stb_q;
      cyc_d       = cyc_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               if (addr_ok) begin
                  state_d = ST_BUS;
                  adr_d   = cmd_addr;
                  dat_d   = cmd_wdata;
                  we_d    = cmd_we;
                  sel_d   = cmd_sel;
                  cyc_d   = 1'b1;
                  stb_d   = 1'b1;
               end else begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = '0;
                  rsp_err_d   = ERR_DEC;
               end
            end
         end
         ST_BUS: begin
            // Ack is checked first so it wins over a simultaneous timeout.
            if (ack_i) begin
               state_d     = ST_RESP;
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = we_q ? '0 : dat_i;
               rsp_err_d   = ERR_OK;
            end else if (tmo_expired) begin
               state_d     = ST_RESP;
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = ERR_TMO;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= ERR_OK;
         adr_q       <= '0;
         dat_q       <= '0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         stb_q       <= 1'b0;
         cyc_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         stb_q       <= stb_d;
         cyc_q       <= cyc_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign adr_o     = adr_q;
   assign dat_o     = dat_q;
   assign we_o      = we_q;
   assign sel_o     = sel_q;
   assign stb_o     = stb_q;
   assign cyc_o     = cyc_q;

endmodule

// File: tb/tb_sys_xbus_master.sv
// Scoreboard bench for sys_xbus_master against a 1-cycle-ack register slave model.
module tb_sys_xbus_master;
   import sys_xbus_master_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_sel;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic [31:0] adr_o, dat_o, dat_i;
   logic        we_o, stb_o, cyc_o, ack_i;
   logic [3:0]  sel_o;

   always #5 clk = ~clk;

   sys_xbus_master #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .SELECT_WIDTH   (4),
      .REG_ADDR_BASE  (32'h1000_0000),
      .NUM_REG        (64),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_sel   (cmd_sel),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .adr_o     (adr_o),
      .dat_o     (dat_o),
      .we_o      (we_o),
      .sel_o     (sel_o),
      .stb_o     (stb_o),
      .cyc_o     (cyc_o),
      .dat_i     (dat_i),
      .ack_i     (ack_i)
   );

   // Register slave model: registered ack one cycle after stb.
   logic [31:0] mem [64];
   logic        ack_q, ack_en, stray_ack;
   logic [3:0]  last_sel;

   function automatic logic [31:0] init_val(input int i);
      if (i == 0)  return 32'h1234_5678;
      if (i == 63) return 32'hCAFE_F00D;
      return 32'h5A00_0000 | 32'(i);
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         ack_q    <= 1'b0;
         last_sel <= 4'h0;
         for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      end else begin
         ack_q <= cyc_o & stb_o & ~ack_q & ack_en;
         if (cyc_o & stb_o & ~ack_q & ack_en & we_o) begin
            mem[adr_o[7:2]] <= dat_o;
            last_sel        <= sel_o;
         end
      end
   end

   assign dat_i = mem[adr_o[7:2]];
   assign ack_i = ack_q | stray_ack;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt++;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  err;
      int          issue;
      int          lat;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;
   bit   in_rsp = 1'b0;
   int   stb_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   // Monitor: pops one expectation per response and checks it every cycle it is held.
   always @(negedge clk) begin
      if (stb_o) stb_cnt++;
      if (rst_n && rsp_valid) begin
         if (!in_rsp) begin
            in_rsp = 1'b1;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got rsp_valid with empty scoreboard (cycle %0d)", cyc_cnt);
               cur = '{32'h0, 2'b00, 0, -1};
            end else begin
               cur = sb.pop_front();
               if (cur.lat >= 0) check("rsp_latency", 64'(cyc_cnt - cur.issue), 64'(cur.lat));
            end
         end
         check("rsp_rdata", rsp_rdata, cur.rdata);
         check("rsp_err", rsp_err, cur.err);
         check("cmd_ready_in_resp", cmd_ready, 0);
         check("cyc_in_resp", cyc_o, 0);
         if (rsp_ready) in_rsp = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel, output int c);
      int n = 0;
      while (!cmd_ready && n < 200) begin
         tick();
         n++;
      end
      if (!cmd_ready) begin
         checks++;
         errors++;
         $display("FAIL cmd_ready_wait: got cmd_ready=0 expected 1 within 200 cycles");
      end
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_sel   = sel;
      c         = cyc_cnt;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0 && !in_rsp && cmd_ready) return;
         tick();
      end
      checks++;
      errors++;
      $display("FAIL rsp_wait: got pending=%0d expected 0 within 200 cycles", sb.size());
   endtask

   task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] sel, input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                      input int lat, input int exp_stb);
      int c;
      stb_cnt = 0;
      issue(we, addr, wdata, sel, c);
      sb.push_back('{exp_rdata, exp_err, c, lat});
      wait_done();
      check("stb_high_cycles", 64'(stb_cnt), 64'(exp_stb));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int c;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_sel   = '0;
      rsp_ready = 1'b1;
      ack_en    = 1'b1;
      stray_ack = 1'b0;
      repeat (3) tick();

      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_adr", adr_o, 0);
      check("rst_dat", dat_o, 0);
      check("rst_sel", sel_o, 0);
      check("rst_we", we_o, 0);
      check("rst_stb", stb_o, 0);
      check("rst_cyc", cyc_o, 0);
      rst_n = 1'b1;
      tick();
      check("idle_cmd_ready", cmd_ready, 1);

      // Ack while idle must not start or complete anything.
      stray_ack = 1'b1;
      repeat (3) tick();
      stray_ack = 1'b0;
      check("stray_ack_cyc", cyc_o, 0);
      check("stray_ack_cmd_ready", cmd_ready, 1);

      run(1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0, ERR_OK, 3, 2);
      check("slave_wr_reg", mem[16], 32'hDEAD_BEEF);
      check("slave_wr_sel", last_sel, 4'hF);
      run(1'b0, 32'h1000_0000, 32'h0, 4'hF, 32'h1234_5678, ERR_OK, 3, 2);
      run(1'b0, 32'h1000_00FC, 32'h0, 4'hF, 32'hCAFE_F00D, ERR_OK, 3, 2);
      run(1'b0, 32'h1000_0100, 32'h0, 4'hF, 32'h0, ERR_DEC, 1, 0);
      run(1'b0, 32'h1000_0002, 32'h0, 4'hF, 32'h0, ERR_DEC, 1, 0);
      run(1'b0, 32'h0FFF_FFFC, 32'h0, 4'hF, 32'h0, ERR_DEC, 1, 0);
      run(1'b1, 32'hFFFF_FFFC, 32'h1, 4'hF, 32'h0, ERR_DEC, 1, 0);

      ack_en = 1'b0;
      run(1'b0, 32'h1000_0004, 32'h0, 4'hF, 32'h0, ERR_TMO, 17, 16);
      ack_en = 1'b1;

      // Backpressured response with a second command waiting behind it.
      rsp_ready = 1'b0;
      issue(1'b0, 32'h1000_0000, 32'h0, 4'hF, c);
      sb.push_back('{32'h1234_5678, ERR_OK, c, 3});
      for (int i = 0; i < 20 && !rsp_valid; i++) tick();
      stb_cnt   = 0;
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_addr  = 32'h2000_0000;
      sb.push_back('{32'h0, ERR_DEC, 0, -1});
      repeat (5) tick();
      rsp_ready = 1'b1;
      for (int i = 0; i < 20 && !cmd_ready; i++) tick();
      tick();
      cmd_valid = 1'b0;
      wait_done();
      check("stall_no_bus", 64'(stb_cnt), 64'(0));

      // Reset while a bus cycle is pending and another command is offered.
      ack_en = 1'b0;
      issue(1'b1, 32'h1000_0008, 32'h1111_2222, 4'hF, c);
      tick();
      rst_n     = 1'b0;
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_addr  = 32'h1000_000C;
      tick();
      check("midrst_cyc", cyc_o, 0);
      check("midrst_stb", stb_o, 0);
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_cmd_ready", cmd_ready, 0);
      tick();
      rst_n     = 1'b1;
      cmd_valid = 1'b0;
      ack_en    = 1'b1;
      tick();
      check("postrst_rsp_valid", rsp_valid, 0);
      run(1'b0, 32'h1000_0000, 32'h0, 4'hF, 32'h1234_5678, ERR_OK, 3, 2);

      repeat (3) tick();
      check("sb_empty", 64'(sb.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
